load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 54 +++++
 rtl/lsu_align.sv | 54 +++++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// byte-lane indices and the captured-request payload.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned LANE_W = 2;

    // Access size encoding; 2'b11 behaves as a word access.
    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } lsu_size_e;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4
    } lsu_state_e;

    // Byte-lane indices within a memory word (little-endian).
    localparam logic [LANE_W-1:0] LANE_0 = 2'd0;
    localparam logic [LANE_W-1:0] LANE_1 = 2'd1;
    localparam logic [LANE_W-1:0] LANE_2 = 2'd2;
    localparam logic [LANE_W-1:0] LANE_3 = 2'd3;

    // Request fields still needed after acceptance.
    typedef struct packed {
        lsu_size_e         size;
        logic              sgn;
        logic [LANE_W-1:0] lane;
        logic [XLEN-1:0]   wdata;
    } lsu_req_t;

    // Word-class sizes (10 and 11) have the upper size bit set.
    function automatic logic is_word(input lsu_size_e size);
        return size[1];
    endfunction

    // Effective lane: half ignores addr[0], word ignores addr[1:0].
    function automatic logic [LANE_W-1:0] lane_of(input lsu_size_e size,
                                                  input logic [LANE_W-1:0] addr_lo);
        case (size)
            SIZE_BYTE: return addr_lo;
            SIZE_HALF: return {addr_lo[1], 1'b0};
            default:   return LANE_0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane extract/extend for loads and lane merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e         size,
    input  logic              sgn,
    input  logic [LANE_W-1:0] lane,
    input  logic [XLEN-1:0]   rdata,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_c,
    output logic [XLEN-1:0]   merge_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed lane and zero/sign-extend it.
    always_comb begin
        byte_v = rdata[7:0];
        case (lane)
            LANE_1:  byte_v = rdata[15:8];
            LANE_2:  byte_v = rdata[23:16];
            LANE_3:  byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: load_c = {{24{sgn & byte_v[7]}}, byte_v};
            SIZE_HALF: load_c = {{16{sgn & half_v[15]}}, half_v};
            default:   load_c = rdata;
        endcase
    end

    // Overlay the store data onto the addressed lane of the old word.
    always_comb begin
        merge_c = rdata;
        case (size)
            SIZE_BYTE: begin
                case (lane)
                    LANE_1:  merge_c[15:8]  = wdata[7:0];
                    LANE_2:  merge_c[23:16] = wdata[7:0];
                    LANE_3:  merge_c[31:24] = wdata[7:0];
                    default: merge_c[7:0]   = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane[1]) merge_c[31:16] = wdata[15:0];
                else         merge_c[15:0]  = wdata[15:0];
            end
            default: merge_c = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time into a word-wide data memory,
// sub-word stores via read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses
// instead of silently aligning them.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            Req_valid,
    output logic            Req_ready,
    input  logic            Req_write,
    input  logic [1:0]      Req_size,
    input  logic            Req_signed,
    input  logic [XLEN-1:0] Req_addr,
    input  logic [XLEN-1:0] Req_wdata,
    output logic            Done,
    output logic [XLEN-1:0] Load_data,
    output logic            Misaligned,
    output logic [XLEN-1:0] Mem_Address,
    output logic [XLEN-1:0] Mem_Write_data,
    output logic            Mem_MemWrite,
    output logic            Mem_MemRead,
    input  logic [XLEN-1:0] Mem_Read_data
);

    lsu_state_e      state, state_nxt;
    lsu_req_t        req, req_nxt;
    lsu_size_e       size_c;
    logic            accept_c;
    logic            misalign_c;
    logic            ready_nxt, done_nxt, mis_nxt, mrd_nxt, mwr_nxt;
    logic [XLEN-1:0] ld_nxt, maddr_nxt, mwdata_nxt;
    logic [XLEN-1:0] load_c, merge_c;

    assign size_c   = lsu_size_e'(Req_size);
    assign accept_c = Req_valid && Req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_c = ((size_c == SIZE_HALF) && Req_addr[0]) ||
                        (is_word(size_c) && (Req_addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    lsu_align u_align (
        .size    (req.size),
        .sgn     (req.sgn),
        .lane    (req.lane),
        .rdata   (Mem_Read_data),
        .wdata   (req.wdata),
        .load_c  (load_c),
        .merge_c (merge_c)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt  = state;
        req_nxt    = req;
        ready_nxt  = 1'b0;
        done_nxt   = 1'b0;
        mis_nxt    = 1'b0;
        ld_nxt     = Load_data;
        maddr_nxt  = '0;
        mwdata_nxt = '0;
        mrd_nxt    = 1'b0;
        mwr_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_nxt = 1'b1;
                if (accept_c) begin
                    req_nxt.size  = size_c;
                    req_nxt.sgn   = Req_signed;
                    req_nxt.lane  = lane_of(size_c, Req_addr[1:0]);
                    req_nxt.wdata = Req_wdata;
                    if (misalign_c) begin
                        mis_nxt  = 1'b1;
                        done_nxt = 1'b1;
                    end else begin
                        ready_nxt = 1'b0;
                        maddr_nxt = {Req_addr[XLEN-1:2], 2'b00};
                        if (!Req_write) begin
                            state_nxt = ST_READ;
                            mrd_nxt   = 1'b1;
                        end else if (is_word(size_c)) begin
                            state_nxt  = ST_WRITE;
                            mwr_nxt    = 1'b1;
                            mwdata_nxt = Req_wdata;
                        end else begin
                            state_nxt = ST_RMW_RD;
                            mrd_nxt   = 1'b1;
                        end
                    end
                end
            end
            ST_READ: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
                done_nxt  = 1'b1;
                ld_nxt    = load_c;
            end
            ST_RMW_RD: begin
                state_nxt  = ST_RMW_WR;
                maddr_nxt  = Mem_Address;
                mwr_nxt    = 1'b1;
                mwdata_nxt = merge_c;
            end
            ST_WRITE, ST_RMW_WR: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

    // State, captured request and registered outputs.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state          <= ST_IDLE;
            req            <= '0;
            Req_ready      <= 1'b1;
            Done           <= 1'b0;
            Misaligned     <= 1'b0;
            Load_data      <= '0;
            Mem_Address    <= '0;
            Mem_Write_data <= '0;
            Mem_MemRead    <= 1'b0;
            Mem_MemWrite   <= 1'b0;
        end else begin
            state          <= state_nxt;
            req            <= req_nxt;
            Req_ready      <= ready_nxt;
            Done           <= done_nxt;
            Misaligned     <= mis_nxt;
            Load_data      <= ld_nxt;
            Mem_Address    <= maddr_nxt;
            Mem_Write_data <= mwdata_nxt;
            Mem_MemRead    <= mrd_nxt;
            Mem_MemWrite   <= mwr_nxt;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// requests checked against a byte-array memory model.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        Req_valid, Req_ready, Req_write, Req_signed;
    logic [1:0]  Req_size;
    logic [31:0] Req_addr, Req_wdata;
    logic        Done, Misaligned;
    logic [31:0] Load_data;
    logic [31:0] Mem_Address, Mem_Write_data, Mem_Read_data;
    logic        Mem_MemWrite, Mem_MemRead;

    logic [31:0] mem   [0:63];
    logic [7:0]  ref_b [0:255];
    logic [31:0] ld_model;
    int          n_cmp, n_err, rd_cnt, wr_cnt, done_cnt;

    always #5 CLK = ~CLK;

    load_store_unit dut (
        .CLK            (CLK),
        .RST_n          (RST_n),
        .Req_valid      (Req_valid),
        .Req_ready      (Req_ready),
        .Req_write      (Req_write),
        .Req_size       (Req_size),
        .Req_signed     (Req_signed),
        .Req_addr       (Req_addr),
        .Req_wdata      (Req_wdata),
        .Done           (Done),
        .Load_data      (Load_data),
        .Misaligned     (Misaligned),
        .Mem_Address    (Mem_Address),
        .Mem_Write_data (Mem_Write_data),
        .Mem_MemWrite   (Mem_MemWrite),
        .Mem_MemRead    (Mem_MemRead),
        .Mem_Read_data  (Mem_Read_data)
    );

    // Word memory: combinational read, write on rising edge.
    assign Mem_Read_data = mem[Mem_Address[7:2]];
    always @(posedge CLK) if (Mem_MemWrite) mem[Mem_Address[7:2]] <= Mem_Write_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus monitor: count accesses per state cycle and check bus sanity.
    always @(negedge CLK) begin
        if (RST_n) begin
            rd_cnt   += int'(Mem_MemRead);
            wr_cnt   += int'(Mem_MemWrite);
            done_cnt += int'(Done);
            check("rd_wr_exclusive", 32'(Mem_MemRead & Mem_MemWrite), 32'd0);
            if (Mem_MemRead || Mem_MemWrite)
                check("addr_aligned", 32'({Mem_Address[31:8], Mem_Address[1:0]}), 32'd0);
        end
    end

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [7:0] b;
        b = a & 8'hFC;
        return {ref_b[b + 8'd3], ref_b[b + 8'd2], ref_b[b + 8'd1], ref_b[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [7:0] a);
        logic [7:0]  v8;
        logic [15:0] v16;
        logic [7:0]  h;
        if (sz == 2'd0) begin
            v8 = ref_b[a];
            return (sg && v8[7]) ? {24'hFFFFFF, v8} : {24'h0, v8};
        end else if (sz == 2'd1) begin
            h   = a & 8'hFE;
            v16 = {ref_b[h + 8'd1], ref_b[h]};
            return (sg && v16[15]) ? {16'hFFFF, v16} : {16'h0, v16};
        end
        return ref_word(a);
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
        logic [7:0] base;
        int n;
        base = (sz == 2'd0) ? a : (sz == 2'd1) ? (a & 8'hFE) : (a & 8'hFC);
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_b[base + 8'(i)] = wd[8*i +: 8];
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] w);
        mem[a[7:2]] = w;
        for (int i = 0; i < 4; i++) ref_b[(a & 8'hFC) + 8'(i)] = w[8*i +: 8];
    endtask

    // Issue one request, follow it to Done and check the outcome.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [7:0] a, input logic [31:0] wd);
        logic mis;
        int   exp_lat, exp_rd, exp_wr, lat, w;
        mis = TRAP && (((sz == 2'd1) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
        if (mis)             begin exp_lat = 1; exp_rd = 0; exp_wr = 0; end
        else if (!wr)        begin exp_lat = 2; exp_rd = 1; exp_wr = 0; end
        else if (sz[1])      begin exp_lat = 2; exp_rd = 0; exp_wr = 1; end
        else                 begin exp_lat = 3; exp_rd = 1; exp_wr = 1; end
        if (!wr && !mis) ld_model = ref_load(sz, sg, a);
        if (wr && !mis) ref_store(sz, a, wd);

        w = 0;
        while (!Req_ready && w < 20) begin @(posedge CLK); #1; w++; end
        check("req_ready", 32'(Req_ready), 32'd1);

        Req_valid = 1'b1; Req_write = wr; Req_size = sz; Req_signed = sg;
        Req_addr = {24'h0, a}; Req_wdata = wd;
        rd_cnt = 0; wr_cnt = 0;
        @(posedge CLK); #1;
        Req_valid = 1'b0; Req_write = 1'($urandom); Req_size = 2'($urandom);
        Req_signed = 1'($urandom); Req_addr = $urandom; Req_wdata = $urandom;

        lat = 1;
        while (!Done && lat < 8) begin @(posedge CLK); #1; lat++; end
        check("done_seen", 32'(Done), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("misaligned", 32'(Misaligned), 32'(mis));
        check("load_data", Load_data, ld_model);
        check("mem_reads", 32'(rd_cnt), 32'(exp_rd));
        check("mem_writes", 32'(wr_cnt), 32'(exp_wr));
        check("ready_at_done", 32'(Req_ready), 32'd1);
        check("mem_word", mem[a[7:2]], ref_word(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; ld_model = '0;
        RST_n = 1'b0; Req_valid = 1'b0; Req_write = 1'b0; Req_size = 2'd0;
        Req_signed = 1'b0; Req_addr = '0; Req_wdata = '0;
        for (int i = 0; i < 64; i++) preload(8'(i * 4), $urandom);

        repeat (2) @(posedge CLK);
        #1;
        check("rst_done", 32'(Done), 32'd0);
        check("rst_mis", 32'(Misaligned), 32'd0);
        check("rst_load", Load_data, 32'd0);
        check("rst_maddr", Mem_Address, 32'd0);
        check("rst_mrw", 32'({Mem_MemRead, Mem_MemWrite}), 32'd0);
        check("rst_ready", 32'(Req_ready), 32'd1);
        RST_n = 1'b1;
        @(posedge CLK); #1;

        // Signed byte and unsigned half loads from a known word.
        preload(8'h10, 32'h8899AABC);
        do_req(1'b0, 2'd0, 1'b1, 8'h11, 32'h0);
        check("lb_signed", Load_data, 32'hFFFFFFAA);
        do_req(1'b0, 2'd1, 1'b0, 8'h12, 32'h0);
        check("lh_unsigned", Load_data, 32'h00008899);

        // Byte store via read-modify-write.
        do_req(1'b1, 2'd0, 1'b0, 8'h10, 32'hFFFFFF55);
        check("sb_merge", mem[4], 32'h8899AA55);

        // Word store then back-to-back word load.
        do_req(1'b1, 2'd2, 1'b0, 8'h20, 32'h12345678);
        do_req(1'b0, 2'd2, 1'b0, 8'h20, 32'h0);
        check("sw_lw", Load_data, 32'h12345678);

        // Word load from a misaligned address.
        do_req(1'b0, 2'd2, 1'b0, 8'h22, 32'h0);
        check("lw_mis_data", Load_data, 32'h12345678);

        // Reset during the read phase of a half store.
        Req_valid = 1'b1; Req_write = 1'b1; Req_size = 2'd1; Req_signed = 1'b0;
        Req_addr = 32'h10; Req_wdata = 32'h0000BEEF;
        @(posedge CLK); #1;
        Req_valid = 1'b0;
        check("rmw_rd_active", 32'(Mem_MemRead), 32'd1);
        RST_n = 1'b0;
        #1;
        ld_model = '0;
        check("rr_maddr", Mem_Address, 32'd0);
        check("rr_mwdata", Mem_Write_data, 32'd0);
        check("rr_mrw", 32'({Mem_MemRead, Mem_MemWrite}), 32'd0);
        check("rr_done", 32'(Done), 32'd0);
        check("rr_mis", 32'(Misaligned), 32'd0);
        check("rr_load", Load_data, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST_n = 1'b1; wr_cnt = 0; done_cnt = 0;
        repeat (4) @(posedge CLK);
        #1;
        check("rr_no_write", 32'(wr_cnt), 32'd0);
        check("rr_no_done", 32'(done_cnt), 32'd0);
        check("rr_mem_kept", mem[4], 32'h8899AA55);

        // Random traffic against the byte-array model.
        for (int i = 0; i < 80; i++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom_range(0, 255)), $urandom);

        @(posedge CLK); #1;
        check("done_drops", 32'(Done), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
